// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge
//   Bridges the 16-bit CPU memory port to a 32-bit SDRAM controller. Reads
//   select a halfword or byte out of the fetched dword. Writes are always
//   read-modify-write because the controller only writes whole dwords.
//   Completions from the controller are rising edges of level signals.
//
//   Optional feature macro: SDRAM_BRIDGE_RDBUF_EN
//     Adds a one-entry write-through dword buffer. Read hits are answered
//     without touching the controller. Write hits skip the read phase.
//
// Ports
//   CLOCK_50, rst_n        clock and asynchronous active-low reset
//   cpu_req/we/byte/addr   CPU request. Level, held until cpu_ack.
//   cpu_wdata              write data. Byte writes use [7:0].
//   cpu_rdata/ack/err      one-cycle completion with read data or timeout flag
//   cpu_busy               high whenever the bridge is not idle
//   sd_address             {dword address, 1'b0}
//   sd_req_read/write      one-cycle request pulses to the controller
//   sd_data_in/out         write / read dword
//   sd_data_valid          read-done level from the controller
//   sd_write_done          write-done level from the controller
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for cpu_req
// RD_ISSUE | pulse sd_req_read
// RD_WAIT  | wait for rising sd_data_valid, capture / merge dword
// WR_ISSUE | pulse sd_req_write with the merged dword
// WR_WAIT  | wait for rising sd_write_done
// ACK      | one-cycle cpu_ack
// HIT      | buffer hit: select or merge from buffer (RDBUF only)
module sdram_cpu_bridge #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [24:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic [23:0] sd_address,
  output logic        sd_req_read,
  output logic        sd_req_write,
  output logic [31:0] sd_data_in,
  input  logic [31:0] sd_data_out,
  input  logic        sd_data_valid,
  input  logic        sd_write_done
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, ACK
`ifdef SDRAM_BRIDGE_RDBUF_EN
    , HIT
`endif
  } state_t;

  state_t state, state_d;

  logic [22:0] addr_q;
  logic [1:0]  lo_q;
  logic        we_q, byte_q;
  logic [15:0] wdata_q;
  logic [31:0] dword_q;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        dv_q, wc_q;
  logic [TW-1:0] tmo_q;
  logic        dv_edge, wc_edge, timeout, accept, buf_hit;

  function automatic logic [31:0] merge(input logic [31:0] d, input logic [1:0] lo,
                                        input logic bw, input logic [15:0] wd);
    logic [31:0] m;
    m = d;
    if (bw) m[{lo, 3'b000} +: 8] = wd[7:0];
    else    m[{lo[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

  function automatic logic [15:0] pick(input logic [31:0] d, input logic [1:0] lo,
                                       input logic bw);
    if (bw) return {8'h00, d[{lo, 3'b000} +: 8]};
    return d[{lo[1], 4'b0000} +: 16];
  endfunction

  // Edge detectors sample every cycle, so a level already high when a wait
  // state is entered never counts as a completion.
  assign dv_edge = sd_data_valid & ~dv_q;
  assign wc_edge = sd_write_done & ~wc_q;
  // Down-counter is loaded on issue, so the terminal count of 1 marks the
  // ACK_TIMEOUT-th cycle spent waiting.
  assign timeout = (ACK_TIMEOUT != 0) && (tmo_q == TMO_ONE);
  assign accept  = (state == IDLE) && cpu_req && !cpu_ack;

`ifdef SDRAM_BRIDGE_RDBUF_EN
  logic [22:0] buf_tag;
  logic [31:0] buf_data;
  logic        buf_valid;
  assign buf_hit = buf_valid && (buf_tag == cpu_addr[24:2]);
`else
  assign buf_hit = 1'b0;
`endif

  assign sd_address = {addr_q, 1'b0};
  assign sd_data_in = dword_q;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    cpu_ack      = 1'b0;
    cpu_err      = 1'b0;
    cpu_rdata    = 16'h0000;
    sd_req_read  = 1'b0;
    sd_req_write = 1'b0;
    cpu_busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef SDRAM_BRIDGE_RDBUF_EN
          state_d = buf_hit ? HIT : RD_ISSUE;
`else
          state_d = RD_ISSUE;
`endif
        end
      end
      RD_ISSUE: begin
        sd_req_read = 1'b1;
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        if (dv_edge)      state_d = we_q ? WR_ISSUE : ACK;
        else if (timeout) state_d = ACK;
      end
      WR_ISSUE: begin
        sd_req_write = 1'b1;
        state_d      = WR_WAIT;
      end
      WR_WAIT: begin
        if (wc_edge || timeout) state_d = ACK;
      end
`ifdef SDRAM_BRIDGE_RDBUF_EN
      HIT: state_d = we_q ? WR_ISSUE : ACK;
`endif
      ACK: begin
        cpu_ack   = 1'b1;
        cpu_err   = err_q;
        cpu_rdata = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      wdata_q <= '0;
      dword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      wc_q    <= 1'b0;
      tmo_q   <= '0;
`ifdef SDRAM_BRIDGE_RDBUF_EN
      buf_tag   <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
`endif
    end else begin
      dv_q <= sd_data_valid;
      wc_q <= sd_write_done;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= cpu_addr[24:2];
            lo_q    <= cpu_addr[1:0];
            we_q    <= cpu_we;
            byte_q  <= cpu_byte;
            wdata_q <= cpu_wdata;
            err_q   <= 1'b0;
            rdata_q <= '0;
          end
        end
        RD_ISSUE: tmo_q <= TMO_LOAD;
        RD_WAIT: begin
          tmo_q <= tmo_q - TMO_ONE;
          if (dv_edge) begin
            dword_q <= we_q ? merge(sd_data_out, lo_q, byte_q, wdata_q) : sd_data_out;
            rdata_q <= pick(sd_data_out, lo_q, byte_q);
`ifdef SDRAM_BRIDGE_RDBUF_EN
            buf_tag   <= addr_q;
            buf_data  <= sd_data_out;
            buf_valid <= 1'b1;
`endif
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
`ifdef SDRAM_BRIDGE_RDBUF_EN
            buf_valid <= 1'b0;
`endif
          end
        end
        WR_ISSUE: begin
          tmo_q <= TMO_LOAD;
`ifdef SDRAM_BRIDGE_RDBUF_EN
          buf_tag   <= addr_q;
          buf_data  <= dword_q;
          buf_valid <= 1'b1;
`endif
        end
        WR_WAIT: begin
          tmo_q <= tmo_q - TMO_ONE;
          if (!wc_edge && timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
`ifdef SDRAM_BRIDGE_RDBUF_EN
            buf_valid <= 1'b0;
`endif
          end
        end
`ifdef SDRAM_BRIDGE_RDBUF_EN
        HIT: begin
          if (we_q) dword_q <= merge(buf_data, lo_q, byte_q, wdata_q);
          else      rdata_q <= pick(buf_data, lo_q, byte_q);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
